// File: rtl/pitch_unit_tx.sv
// BATS PITCH sequenced-unit transmitter: packs Time / Delete Order commands into
// a payload buffer, then streams a unit header and the payload as 64-bit words.
module pitch_unit_tx #(
    parameter int unsigned UNIT_ID   = 1,
    parameter int unsigned MAX_MSGS  = 16,
    parameter int unsigned MAX_WORDS = 32
) (
    input  logic        Clk40,
    input  logic        reset_n,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [7:0]  msg_type,
    input  logic [31:0] msg_seconds,
    input  logic [31:0] msg_offset_ns,
    input  logic [63:0] msg_order_id,
    input  logic        msg_last,
    output logic [63:0] out_bytes,
    output logic [7:0]  out_byte_enables,
    output logic        out_data_valid,
    input  logic        in_ready_for_udp_input,
    output logic [31:0] seq_next,
    output logic        err_bad_type
);

    // Handshakes: a command moves on a cycle with msg_valid && msg_ready; an output
    // word moves on a cycle with out_data_valid && in_ready_for_udp_input, and the
    // presented word/enables are held unchanged until that happens.

    localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [AW:0]  PTR_ONE   = 1;
    localparam logic [7:0]   MAX_CNT   = 8'(MAX_MSGS);
    localparam logic [15:0]  CLOSE_LIM = 16'(MAX_WORDS * 8 - 14);
    localparam logic [7:0]   UNIT_BYTE = 8'(UNIT_ID);

    typedef enum logic [2:0] {ACCUM, DRAIN2, FLUSH, HDR, DATA} state_t;

    state_t      state, state_nx;
    logic [63:0] mem [MAX_WORDS];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [63:0] acc, pend;
    logic [2:0]  fill;
    logic        pend_vld;
    logic        closing;
    logic [15:0] pay_bytes;
    logic [7:0]  msg_cnt;
    logic [31:0] seq_q;

    logic         xfer, out_xfer;
    logic         is_time, is_del, is_bad;
    logic [4:0]   msg_len, total;
    logic [127:0] msg_vec;
    logic [191:0] wide;
    logic [7:0]   new_cnt;
    logic [15:0]  new_bytes, hdr_len;
    logic         close_now;
    logic [63:0]  hdr_word;
    logic [2:0]   tail;
    logic [7:0]   last_be;
    logic         mem_we;
    logic [63:0]  mem_wd;

    assign msg_ready = (state == ACCUM);
    assign seq_next  = seq_q;
    assign xfer      = msg_valid && msg_ready;
    assign out_xfer  = out_data_valid && in_ready_for_udp_input;

    always_comb begin
        is_time = (msg_type == 8'h20);
        is_del  = (msg_type == 8'h29);
        is_bad  = !is_time && !is_del;
        msg_len = 5'd0;
        msg_vec = '0;
        if (is_time) begin
            msg_len = 5'd6;
            msg_vec = {8'h06, 8'h20, msg_seconds[7:0], msg_seconds[15:8],
                       msg_seconds[23:16], msg_seconds[31:24], 80'b0};
        end else if (is_del) begin
            msg_len = 5'd14;
            msg_vec = {8'h0E, 8'h29, msg_offset_ns[7:0], msg_offset_ns[15:8],
                       msg_offset_ns[23:16], msg_offset_ns[31:24],
                       msg_order_id[7:0], msg_order_id[15:8], msg_order_id[23:16],
                       msg_order_id[31:24], msg_order_id[39:32], msg_order_id[47:40],
                       msg_order_id[55:48], msg_order_id[63:56], 16'b0};
        end
        // Message bytes land right after the accumulator's fill bytes; the three
        // 64-bit slices are the first, second and leftover words.
        wide      = {acc, 128'b0} | ({msg_vec, 64'b0} >> {fill, 3'b000});
        total     = {2'b00, fill} + msg_len;
        new_cnt   = is_bad ? msg_cnt : msg_cnt + 8'd1;
        new_bytes = pay_bytes + {11'b0, msg_len};
        close_now = (msg_last && (new_cnt != 8'd0)) ||
                    (!is_bad && ((new_cnt == MAX_CNT) || (new_bytes > CLOSE_LIM)));
        hdr_len   = pay_bytes + 16'd8;
        hdr_word  = {hdr_len[7:0], hdr_len[15:8], msg_cnt, UNIT_BYTE,
                     seq_q[7:0], seq_q[15:8], seq_q[23:16], seq_q[31:24]};
        tail      = pay_bytes[2:0];
        last_be   = (tail == 3'd0) ? 8'hFF : ~(8'hFF >> tail);
    end

    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        mem_wd   = wide[191:128];
        case (state)
            ACCUM: begin
                if (xfer) begin
                    mem_we = !is_bad && (total >= 5'd8);
                    if (is_del)         state_nx = DRAIN2;
                    else if (close_now) state_nx = FLUSH;
                end
            end
            DRAIN2: begin
                mem_we   = pend_vld;
                mem_wd   = pend;
                state_nx = closing ? FLUSH : ACCUM;
            end
            FLUSH: begin
                mem_we   = (fill != 3'd0);
                mem_wd   = acc;
                state_nx = HDR;
            end
            HDR:  if (out_xfer) state_nx = DATA;
            DATA: if (out_xfer && (rd_ptr == wr_ptr)) state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge Clk40) begin
        if (mem_we) mem[wr_ptr[AW-1:0]] <= mem_wd;
    end

    always_ff @(posedge Clk40) begin
        if (!reset_n) begin
            state            <= ACCUM;
            acc              <= '0;
            fill             <= '0;
            pend             <= '0;
            pend_vld         <= 1'b0;
            closing          <= 1'b0;
            pay_bytes        <= '0;
            msg_cnt          <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            seq_q            <= 32'd1;
            out_bytes        <= '0;
            out_byte_enables <= '0;
            out_data_valid   <= 1'b0;
            err_bad_type     <= 1'b0;
        end else begin
            state        <= state_nx;
            err_bad_type <= xfer && is_bad;
            if (mem_we) wr_ptr <= wr_ptr + PTR_ONE;
            case (state)
                ACCUM: begin
                    if (xfer && !is_bad) begin
                        msg_cnt   <= new_cnt;
                        pay_bytes <= new_bytes;
                        fill      <= total[2:0];
                        pend      <= wide[127:64];
                        pend_vld  <= is_del && total[4];
                        closing   <= close_now;
                        if (total[4])      acc <= wide[63:0];
                        else if (total[3]) acc <= wide[127:64];
                        else               acc <= wide[191:128];
                    end else if (xfer) begin
                        closing <= close_now;
                    end
                end
                DRAIN2: pend_vld <= 1'b0;
                FLUSH: begin
                    acc              <= '0;
                    fill             <= '0;
                    out_bytes        <= hdr_word;
                    out_byte_enables <= 8'hFF;
                    out_data_valid   <= 1'b1;
                end
                HDR, DATA: begin
                    if (out_xfer && (state == DATA) && (rd_ptr == wr_ptr)) begin
                        out_bytes        <= '0;
                        out_byte_enables <= '0;
                        out_data_valid   <= 1'b0;
                        seq_q            <= seq_q + {24'b0, msg_cnt};
                        msg_cnt          <= '0;
                        pay_bytes        <= '0;
                        wr_ptr           <= '0;
                        rd_ptr           <= '0;
                        closing          <= 1'b0;
                    end else if (out_xfer) begin
                        // Registered buffer read straight into the output word.
                        out_bytes        <= mem[rd_ptr[AW-1:0]];
                        out_byte_enables <= ((rd_ptr + PTR_ONE) == wr_ptr) ? last_be : 8'hFF;
                        rd_ptr           <= rd_ptr + PTR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
